// File: rtl/down_timer_ctrl_if.sv
// down_timer_ctrl_if: control and status bundle of the down timer
interface down_timer_ctrl_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] load_val;
  logic start;
  logic pause;
  logic abort;
  logic auto_reload;
  logic tick;
  logic [WIDTH-1:0] count;
  logic [1:0] state;
  logic ready;
  logic busy;
  logic expired;
  modport master (
    output load_val, start, pause, abort, auto_reload, tick,
    input count, state, ready, busy, expired
  );
  modport slave (
    input load_val, start, pause, abort, auto_reload, tick,
    output count, state, ready, busy, expired
  );
endinterface

// File: rtl/down_timer_ctrl.sv
// down_timer_ctrl: tick-driven down counter with pause, abort and auto-reload
module down_timer_ctrl #(parameter int WIDTH = 4) (
  input logic clk,
  input logic reset,
  down_timer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10, DONE = 2'b11} state_t;
  state_t st, st_n;
  logic [WIDTH-1:0] cnt, cnt_n, rld, rld_n;
  logic mode, mode_n, exp_q, exp_n, rdy;
  assign rdy = st == IDLE || st == DONE;
  assign bus.count = cnt;
  assign bus.state = st;
  assign bus.ready = rdy;
  assign bus.busy = !rdy;
  assign bus.expired = exp_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      cnt <= '0;
      rld <= '0;
      mode <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      rld <= rld_n;
      mode <= mode_n;
      exp_q <= exp_n;
    end
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    rld_n = rld;
    mode_n = mode;
    exp_n = 1'b0;
    if (bus.abort) begin
      st_n = IDLE;
      cnt_n = '0;
    end else if (bus.start && rdy) begin
      cnt_n = bus.load_val;
      exp_n = bus.load_val == '0;
      st_n = exp_n ? DONE : RUN;
      rld_n = exp_n ? rld : bus.load_val;
      mode_n = exp_n ? mode : bus.auto_reload;
    end else if (st == PAUSED) begin
      st_n = bus.pause ? PAUSED : RUN;
    end else if (st == RUN && bus.pause) begin
      st_n = PAUSED;
    end else if (st == RUN && bus.tick && cnt > WIDTH'(1)) begin
      cnt_n = cnt - WIDTH'(1);
    end else if (st == RUN && bus.tick && cnt == WIDTH'(1)) begin
      exp_n = 1'b1;
      cnt_n = mode ? rld : '0;
      st_n = mode ? RUN : DONE;
    end
  end
endmodule

// File: tb/tb_down_timer_ctrl.sv
// tb_down_timer_ctrl: vector table, corner sequences and random run against a reference model
module tb_down_timer_ctrl;
  typedef struct {
    int s, p, a, r, t, lv, c, st, e;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int m_st, m_cnt, m_rld, m_mode, m_exp;
  vec_t tbl[$];
  down_timer_ctrl_if #(.WIDTH(4)) bus ();
  down_timer_ctrl #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input int s, input int p, input int a, input int r, input int t, input int lv);
    bus.start = 1'(s);
    bus.pause = 1'(p);
    bus.abort = 1'(a);
    bus.auto_reload = 1'(r);
    bus.tick = 1'(t);
    bus.load_val = 4'(lv);
  endtask
  task automatic model_reset();
    m_st = 0;
    m_cnt = 0;
    m_rld = 0;
    m_mode = 0;
    m_exp = 0;
  endtask
  task automatic model_step();
    bit rd;
    rd = m_st == 0 || m_st == 3;
    m_exp = 0;
    if (bus.abort) begin
      m_st = 0;
      m_cnt = 0;
    end else if (bus.start && rd) begin
      if (bus.load_val == 0) begin
        m_cnt = 0;
        m_st = 3;
        m_exp = 1;
      end else begin
        m_cnt = int'(bus.load_val);
        m_rld = m_cnt;
        m_mode = int'(bus.auto_reload);
        m_st = 1;
      end
    end else if (m_st == 2) begin
      if (!bus.pause) m_st = 1;
    end else if (m_st == 1 && bus.pause) begin
      m_st = 2;
    end else if (m_st == 1 && bus.tick) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else begin
        m_exp = 1;
        if (m_mode != 0) m_cnt = m_rld;
        else begin
          m_cnt = 0;
          m_st = 3;
        end
      end
    end
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("count", 32'(bus.count), m_cnt);
    chk("state", 32'(bus.state), m_st);
    chk("expired", 32'(bus.expired), m_exp);
    chk("ready", 32'(bus.ready), 32'(m_st == 0 || m_st == 3));
    chk("busy", 32'(bus.busy), 32'(m_st == 1 || m_st == 2));
  endtask
  task automatic add(input int s, input int p, input int a, input int r, input int t,
                     input int lv, input int c, input int st, input int e);
    vec_t v;
    v = '{s: s, p: p, a: a, r: r, t: t, lv: lv, c: c, st: st, e: e};
    tbl.push_back(v);
  endtask
  task automatic check_reset_values(input string nm);
    chk({nm, "_count"}, 32'(bus.count), 0);
    chk({nm, "_state"}, 32'(bus.state), 0);
    chk({nm, "_expired"}, 32'(bus.expired), 0);
    chk({nm, "_ready"}, 32'(bus.ready), 1);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_reset_values("rst_async");
    #5;
    check_reset_values("rst_held");
    reset = 1'b1;
    add(1,0,0,0,0,3, 3,1,0); add(0,0,0,0,1,0, 2,1,0); add(0,0,0,0,1,0, 1,1,0);
    add(0,0,0,0,1,0, 0,3,1); add(0,0,0,0,1,0, 0,3,0);
    add(1,0,0,1,1,2, 2,1,0); add(0,0,0,0,1,0, 1,1,0); add(0,0,0,0,1,0, 2,1,1);
    add(0,0,0,0,1,0, 1,1,0); add(0,0,0,0,1,0, 2,1,1);
    add(0,0,1,0,0,0, 0,0,0); add(1,0,0,0,0,5, 5,1,0); add(0,0,0,0,1,0, 4,1,0);
    add(1,0,1,0,1,9, 0,0,0);
    add(1,0,0,0,0,0, 0,3,1); add(0,0,0,0,0,0, 0,3,0); add(1,0,0,0,0,4, 4,1,0);
    add(1,0,0,0,0,7, 4,1,0); add(1,0,0,1,1,7, 3,1,0); add(0,0,0,0,1,0, 2,1,0);
    add(0,0,0,0,1,0, 1,1,0); add(0,0,0,0,1,0, 0,3,1);
    add(1,0,0,0,0,5, 5,1,0); add(0,0,0,0,1,0, 4,1,0); add(0,0,0,0,1,0, 3,1,0);
    add(0,1,0,0,1,0, 3,2,0); add(0,1,0,0,1,0, 3,2,0); add(1,1,0,0,1,9, 3,2,0);
    add(0,1,0,0,1,0, 3,2,0); add(0,0,0,0,1,0, 3,1,0); add(0,0,0,0,1,0, 2,1,0);
    add(0,0,0,0,1,0, 1,1,0); add(0,0,0,0,0,0, 1,1,0); add(0,0,0,0,1,0, 0,3,1);
    add(0,0,1,0,0,0, 0,0,0);
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].r, tbl[i].t, tbl[i].lv);
      cyc();
      chk($sformatf("vec%0d_count", i), 32'(bus.count), tbl[i].c);
      chk($sformatf("vec%0d_state", i), 32'(bus.state), tbl[i].st);
      chk($sformatf("vec%0d_expired", i), 32'(bus.expired), tbl[i].e);
    end
    drive(1, 0, 0, 0, 0, 8);
    cyc();
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    cyc();
    chk("pre_reset_count", 32'(bus.count), 6);
    reset = 1'b0;
    #2;
    check_reset_values("mid_run_rst");
    model_reset();
    #2;
    reset = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    chk("after_rst_idle", 32'(bus.state), 0);
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15));
      cyc();
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        #1;
        check_reset_values("rand_rst");
        model_reset();
        reset = 1'b1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/down_timer_ctrl.md
DOWN_TIMER_CTRL -- requirements
Module: down_timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of the count datapath.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port load_val  input  WIDTH  start value, sampled on accepted start.
REQ-005 Port start  input  1  start request; accepted only when ready=1.
REQ-006 Port pause  input  1  level-sensitive hold request.
REQ-007 Port abort  input  1  cancel request, any state.
REQ-008 Port auto_reload  input  1  reload mode, sampled on accepted start.
REQ-009 Port tick  input  1  decrement strobe; one decrement per tick cycle in RUN.
REQ-010 Port count  output  WIDTH  current registered count value.
REQ-011 Port state  output  2  FSM state encoding: IDLE=00, RUN=01, PAUSED=10, DONE=11.
REQ-012 Port ready  output  1  1 in IDLE or DONE (start may be accepted).
REQ-013 Port busy  output  1  1 in RUN or PAUSED; ready and busy always complementary.
REQ-014 Port expired  output  1  registered one-cycle pulse on each terminal count.

Function
REQ-015 Internal registers SHALL be count, reload value (WIDTH), latched reload mode, state, expired.
REQ-016 Per-cycle priority SHALL be abort > start > pause > tick.
REQ-017 abort in any state SHALL give, next cycle, state=IDLE, count=0, expired=0.
REQ-018 Accepted start (ready=1, no abort) with load_val!=0 SHALL load count=load_val, reload=load_val, latch auto_reload, enter RUN.
REQ-019 Accepted start with load_val=0 SHALL give count=0, state=DONE, expired=1 for one cycle.
REQ-020 start while busy=1 SHALL be ignored, with no change to count, reload or mode.
REQ-021 RUN, pause=1: enter PAUSED next cycle; a same-cycle tick is dropped.
REQ-022 PAUSED: count held, ticks ignored; pause=0 returns to RUN next cycle.
REQ-023 RUN, tick=1, count>1: count decrements by 1, state stays RUN.
REQ-024 RUN, tick=1, count=1, latched mode=1: count=reload, stay RUN, expired=1 for one cycle.
REQ-025 RUN, tick=1, count=1, latched mode=0: count=0, enter DONE, expired=1 for one cycle.
REQ-026 RUN, tick=0: count and state held.
REQ-027 DONE: count held at 0 until start or abort.
REQ-028 Arithmetic SHALL be unsigned WIDTH-bit; count never wraps below 0 (no 0->all-ones transition).
REQ-029 Changing auto_reload or load_val while busy SHALL have no effect on the current run.
REQ-030 Latency: start-to-RUN 1 cycle; tick-to-count update 1 cycle; expired coincides with the terminal count/state update.

Reset
REQ-031 reset=0 SHALL immediately (no clock needed) force state=IDLE, count=0, reload=0, latched mode=0, expired=0.
REQ-032 Consequently during reset ready=1, busy=0; deassertion mid-run SHALL resume from IDLE, with the prior run lost.
REQ-033 The first active edge after reset deasserts SHALL obey REQ-016..REQ-030 with no extra wait cycles.

Verification
REQ-034 Directed scenario: load_val=3, start, tick every cycle, mode=0 -> count 3,2,1,0; DONE entered with expired=1 exactly once; ready=1 afterwards.
REQ-035 Directed scenario: load_val=2, mode=1, continuous tick -> count 2,1,2,1,...; expired pulses every 2nd tick; state stays RUN.
REQ-036 Directed scenario: load_val=5, two ticks, pause=1 with tick for 4 cycles, then pause=0 -> count holds 3 while PAUSED; decrements resume after return to RUN.
REQ-037 Directed scenario: abort+start+tick in the same RUN cycle at count=4 -> next cycle IDLE, count=0, expired=0.
REQ-038 Directed scenario: load_val=0, start -> DONE, count=0, expired=1 one cycle; start while busy with load_val=7 -> ignored.
REQ-039 Directed scenario: reset=0 pulsed asynchronously mid-RUN (count=6) between edges -> outputs go to reset values before the next edge.
